// File: rtl/fc_class_accum.sv
// fc_class_accum: ten-class fixed-point dot-product accumulator with bias and Q.8 rescale.
// Define FC_SAT_EN to clamp scores to [0, 65535]; otherwise scores wrap to 16 bits.
module fc_class_accum #(
  parameter int N_IN      = 84,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_data,
  input  logic [159:0] weight_bus,
  input  logic [159:0] bias_bus,
  output logic [6:0]   feat_idx,
  output logic [15:0]  class0,
  output logic [15:0]  class1,
  output logic [15:0]  class2,
  output logic [15:0]  class3,
  output logic [15:0]  class4,
  output logic [15:0]  class5,
  output logic [15:0]  class6,
  output logic [15:0]  class7,
  output logic [15:0]  class8,
  output logic [15:0]  class9,
  output logic         out_valid
);
  typedef enum logic [1:0] {ACCUM, DRAIN1, DRAIN2, DONE} state_t;
  state_t state, state_nxt;
  logic accept, last, p_valid;
  logic signed [31:0] prod [10];
  logic signed [ACC_W-1:0] acc [10];
  logic signed [ACC_W-1:0] sum [10];
  logic [15:0] score [10];
  logic [15:0] score_nxt [10];
  assign in_ready = state == ACCUM;
  assign accept = in_valid && in_ready;
  assign last = feat_idx == 7'(N_IN - 1);
  always_comb begin
    state_nxt = state == ACCUM  ? (accept && last ? DRAIN1 : ACCUM) :
                state == DRAIN1 ? DRAIN2 :
                state == DRAIN2 ? DONE : ACCUM;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      feat_idx <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      out_valid <= state == DONE;
      if (accept) feat_idx <= last ? 7'd0 : feat_idx + 7'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      for (int k = 0; k < 10; k++) prod[k] <= '0;
    end else begin
      p_valid <= accept;
      if (accept)
        for (int k = 0; k < 10; k++) prod[k] <= $signed(in_data) * $signed(weight_bus[16*k +: 16]);
    end
  end
  // bias is promoted to the Q.16 product scale before the final rescale
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      sum[k] = acc[k] + ($signed({{(ACC_W-16){bias_bus[16*k+15]}}, bias_bus[16*k +: 16]}) <<< FRAC_BITS);
`ifdef FC_SAT_EN
      score_nxt[k] = sum[k][ACC_W-1] ? 16'd0 :
                     (|sum[k][ACC_W-2:16+FRAC_BITS]) ? 16'hFFFF : sum[k][15+FRAC_BITS:FRAC_BITS];
`else
      score_nxt[k] = 16'(sum[k] >>> FRAC_BITS);
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 10; k++) begin
        acc[k] <= '0;
        score[k] <= '0;
      end
    end else if (state == DONE) begin
      for (int k = 0; k < 10; k++) begin
        acc[k] <= '0;
        score[k] <= score_nxt[k];
      end
    end else if (p_valid) begin
      for (int k = 0; k < 10; k++) acc[k] <= acc[k] + {{(ACC_W-32){prod[k][31]}}, prod[k]};
    end
  end
  assign class0 = score[0];
  assign class1 = score[1];
  assign class2 = score[2];
  assign class3 = score[3];
  assign class4 = score[4];
  assign class5 = score[5];
  assign class6 = score[6];
  assign class7 = score[7];
  assign class8 = score[8];
  assign class9 = score[9];
endmodule

// File: tb/tb_fc_class_accum.sv
// tb_fc_class_accum: directed frames with a queued scoreboard checked by a negedge monitor.
module tb_fc_class_accum;
  localparam int N = 84;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready, out_valid;
  logic [15:0] in_data = '0;
  logic [159:0] weight_bus = '0;
  logic [159:0] bias_bus = '0;
  logic [6:0] feat_idx;
  logic [15:0] class0, class1, class2, class3, class4, class5, class6, class7, class8, class9;
  logic [159:0] cls, held;
  logic [159:0] exp_q[$];
  int cyc_q[$];
  int cyc = 0;
  int lowcnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  fc_class_accum #(.N_IN(N), .FRAC_BITS(8), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight_bus(weight_bus), .bias_bus(bias_bus), .feat_idx(feat_idx),
    .class0(class0), .class1(class1), .class2(class2), .class3(class3), .class4(class4),
    .class5(class5), .class6(class6), .class7(class7), .class8(class8), .class9(class9),
    .out_valid(out_valid)
  );

  assign cls = {class9, class8, class7, class6, class5, class4, class3, class2, class1, class0};
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded required bound 60000", cyc);
      $fatal(1);
    end
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] rep(input logic [15:0] v);
    logic [159:0] r;
    for (int k = 0; k < 10; k++) r[16*k +: 16] = v;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held = '0;
      lowcnt = 0;
    end else begin
      if (!in_ready) lowcnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1'b1, 1'b0);
        else begin
          chk("scores", cls, exp_q.pop_front());
          chk("latency", cyc, cyc_q.pop_front());
          chk("in_ready_low_cycles", lowcnt, 3);
        end
        held = cls;
        lowcnt = 0;
      end else chk("hold", cls, held);
    end
  end

  task automatic send(input logic [15:0] d, input logic [159:0] w, input int idx, input bit gap);
    int t;
    if (gap) begin
      in_valid = 1'b0;
      in_data = 16'hDEAD;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = d;
    weight_bus = w;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    chk("feat_idx", feat_idx, idx);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] d, input logic [159:0] w, input logic [159:0] b,
                       input logic [159:0] e, input bit gaps, input int nb);
    bias_bus = b;
    for (int i = 0; i < nb; i++) send(d, w, i, gaps ? 1'($urandom_range(0, 1)) : 1'b0);
    if (nb == N) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + 3);
      chk("feat_idx_wrap", feat_idx, 0);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    cyc_q.delete();
  endtask

  initial begin
    logic [159:0] bias_k, exp_k, w_ramp, exp_ramp, exp_neg;
    for (int k = 0; k < 10; k++) begin
      bias_k[16*k +: 16] = 16'(k * 256);
      exp_k[16*k +: 16] = 16'h5400 + 16'(k * 256);
      w_ramp[16*k +: 16] = 16'(k * 64);
      exp_ramp[16*k +: 16] = 16'(k * 16'h1500);
    end
`ifdef FC_SAT_EN
    exp_neg = '0;
`else
    exp_neg = rep(16'hAC00);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_classes", cls, '0);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_feat_idx", feat_idx, 0);
    frame(16'h0100, rep(16'h0100), '0, rep(16'h5400), 1'b0, N);
    wait_idle();
    frame(16'h0100, rep(16'h0100), bias_k, exp_k, 1'b0, N);
    frame(16'h0100, rep(16'h0100), bias_k, exp_k, 1'b1, N);
    wait_idle();
    frame(16'h0100, rep(16'hFF00), '0, exp_neg, 1'b0, N);
    wait_idle();
    frame(16'h0100, rep(16'h0100), '0, '0, 1'b0, 40);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_classes", cls, '0);
    chk("midrst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_feat_idx", feat_idx, 0);
    frame(16'h0100, rep(16'h0100), '0, rep(16'h5400), 1'b0, N);
    frame(16'h0200, rep(16'h0100), '0, rep(16'hA800), 1'b0, N);
    frame(16'h0100, w_ramp, '0, exp_ramp, 1'b0, N);
    wait_idle();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_class_accum.md
FC_CLASS_ACCUM -- requirements
Module: fc_class_accum

Interface
REQ-001 SHALL have parameter N_IN, default 84, meaning feature beats per frame (2..127).
REQ-002 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits of each input and each weight (Q.8 x Q.8 -> Q.16 product).
REQ-003 SHALL have parameter ACC_W, default 40, meaning signed accumulator width per class.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data and weight_bus are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-009 SHALL have port in_data, input, 16 bits: signed feature value.
REQ-010 SHALL have port weight_bus, input, 160 bits: ten signed 16-bit weights; class k is bits [16k+15:16k]; aligned with in_data.
REQ-011 SHALL have port bias_bus, input, 160 bits: ten signed 16-bit biases in Q.8 format; held static.
REQ-012 SHALL have port feat_idx, output, 7 bits: index of the next beat to accept, used as the weight ROM address (combinational ROM).
REQ-013 SHALL have ports class0..class9, output, 16 bits each: unsigned class scores, which feed the downstream argmax stage.
REQ-014 SHALL have port out_valid, output, 1 bit: one-cycle pulse when class0..9 update.

Function
REQ-015 SHALL accept a beat when in_valid and in_ready are both high; in_ready SHALL equal (state==ACCUM).
REQ-016 SHALL implement the states ACCUM, DRAIN1, DRAIN2 and DONE.
REQ-017 SHALL move ACCUM->DRAIN1 on acceptance of beat N_IN-1, then DRAIN1->DRAIN2->DONE->ACCUM unconditionally, one cycle each.
REQ-018 SHALL increment feat_idx on each accepted beat and reset it to 0 on the beat that completes the frame (the same cycle the state leaves ACCUM).
REQ-019 SHALL use a 2-stage pipeline: stage 1 registers ten 32-bit signed products in_data*weight_k together with a valid bit; stage 2 adds the sign-extended products to acc_k.
REQ-020 SHALL register in DONE: score_k = (acc_k + (bias_k << FRAC_BITS)) >>> (2*FRAC_BITS - FRAC_BITS), i.e. an arithmetic right shift by FRAC_BITS, giving a Q.8 result.
REQ-021 SHALL clear acc_k to 0 in DONE, in the same cycle the scores are registered.
REQ-022 SHALL produce out_valid exactly 3 cycles after the clock edge that accepted the last beat.
REQ-023 SHALL hold class0..9 stable between out_valid pulses.
REQ-024 SHALL leave all state unchanged when in_valid is low in ACCUM (gaps allowed anywhere, including before the last beat).
REQ-025 SHALL ignore in_valid outside ACCUM; no beat is lost or double-counted.

Reset
REQ-026 SHALL, on rst asserted, immediately set state=ACCUM, feat_idx=0, in_ready=1 after deassertion, out_valid=0, class0..9=0, all acc_k=0 and the pipeline valid bit=0.
REQ-027 SHALL discard a partial frame when reset is asserted mid-frame or mid-drain; no out_valid results from it.

Configuration
REQ-028 SHALL, with FC_SAT_EN defined, clamp each score to [0, 65535]: negative -> 0, over range -> 16'hFFFF.
REQ-029 SHALL, with FC_SAT_EN undefined, output each score as the low 16 bits of the shifted sum (wrap; negatives appear as large unsigned values).

Verification
REQ-030 SHALL cover: N_IN=84, in_data=16'h0100 and all weights 16'h0100 every beat, bias 0 -> class0..9=16'h5400 (84.0), out_valid pulse at +3 cycles after the last beat.
REQ-031 SHALL cover: same stimulus with bias_k=k*16'h0100 -> class_k=16'h5400+k*16'h0100; feat_idx runs 0..83 and then returns to 0.
REQ-032 SHALL cover: random in_valid gaps (50%) -> results identical to the gapless run; in_ready low for exactly 3 cycles per frame.
REQ-033 SHALL cover: weights all 16'hFF00 (-1.0), in_data=16'h0100 -> with FC_SAT_EN class=0; without FC_SAT_EN class=16'hAC00.
REQ-034 SHALL cover: rst pulsed after 40 beats, then a full frame of REQ-030 stimulus -> no out_valid from the aborted frame, and the second frame gives 16'h5400.
REQ-035 SHALL cover: two back-to-back frames with different data -> the first frame's outputs hold until the second out_valid, and the accumulators start from 0.
